jtvigil_obj_draw: RTL and testbench

JTVIGIL_OBJ_DRAW -- requirements
Module: jtvigil_obj_draw

---
 rtl/jtvigil_obj_draw.sv | 204 ++++++++++++++++++++
 tb/tb_jtvigil_obj_draw.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtvigil_obj_draw.sv
// jtvigil_obj_draw: sprite row renderer into ping-pong 512x8 line buffers.
// Define JTVIGIL_OBJ_HFLIP_EN to honour the hflip input (ignored otherwise).
module jtvigil_obj_draw (
   input  logic        clk,
   input  logic        rst,
   input  logic        pxl_cen,
   input  logic        LHBL,
   input  logic [8:0]  h,
   input  logic        draw,
   output logic        busy,
   input  logic [8:0]  xpos,
   input  logic [3:0]  pal,
   input  logic [16:0] code,
   input  logic        hflip,
   output logic [17:0] rom_addr,
   output logic        rom_cs,
   input  logic [31:0] rom_data,
   input  logic        rom_ok,
   output logic [7:0]  pxl
);

   typedef enum logic [2:0] {
      IDLE,
      REQ0,
      DRAW0,
      REQ1,
      DRAW1
   } state_t;

   state_t      state_q;
   logic [8:0]  xpos_q;
   logic [3:0]  pal_q;
   logic [16:0] code_q;
   logic        flip_q;
   logic [31:0] data_q;
   logic [2:0]  cnt_q;
   logic        busy_q;
   logic        cs_q;
   logic [17:0] addr_q;
   logic        bank_q;
   logic        lhbl_q;
   logic [7:0]  pxl_q;
   logic        erase_q;
   logic        ebank_q;
   logic [8:0]  eaddr_q;

   logic [7:0]  buf0 [0:511];
   logic [7:0]  buf1 [0:511];

   logic        swap;
   logic        in_draw;
   logic        flip_in;
   logic [3:0]  off;
   logic [3:0]  nib;
   logic [8:0]  col;
   logic        dwe;
   logic [7:0]  dval;
   logic        we0;
   logic        we1;
   logic [8:0]  wa0;
   logic [8:0]  wa1;
   logic [7:0]  wd0;
   logic [7:0]  wd1;

`ifdef JTVIGIL_OBJ_HFLIP_EN
   assign flip_in = hflip;
`else
   assign flip_in = hflip & 1'b0;
`endif

   assign swap    = lhbl_q & ~LHBL;
   assign in_draw = (state_q == DRAW0) || (state_q == DRAW1);
   assign off     = {state_q == DRAW1, cnt_q};
   assign nib     = data_q[{cnt_q, 2'b00} +: 4];
   assign col     = xpos_q + {5'd0, flip_q ? ~off : off};
   assign dwe     = in_draw & ~swap & ~rst & (nib != 4'd0);
   assign dval    = {pal_q, nib};

   // Draw writes go to bank_q, erases to the bank that was read.
   always_comb begin
      we0 = 1'b0;
      we1 = 1'b0;
      wa0 = eaddr_q;
      wa1 = eaddr_q;
      wd0 = 8'h00;
      wd1 = 8'h00;
      if (erase_q && !rst) begin
         if (ebank_q) we1 = 1'b1;
         else         we0 = 1'b1;
      end
      if (dwe) begin
         if (bank_q) begin
            we1 = 1'b1;
            wa1 = col;
            wd1 = dval;
         end else begin
            we0 = 1'b1;
            wa0 = col;
            wd0 = dval;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (we0) buf0[wa0] <= wd0;
      if (we1) buf1[wa1] <= wd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         xpos_q  <= 9'd0;
         pal_q   <= 4'd0;
         code_q  <= 17'd0;
         flip_q  <= 1'b0;
         data_q  <= 32'd0;
         cnt_q   <= 3'd0;
         busy_q  <= 1'b0;
         cs_q    <= 1'b0;
         addr_q  <= 18'd0;
         bank_q  <= 1'b0;
         lhbl_q  <= 1'b0;
      end else begin
         lhbl_q <= LHBL;
         if (swap) begin
            bank_q  <= ~bank_q;
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cs_q    <= 1'b0;
         end else begin
            unique case (state_q)
               IDLE: begin
                  if (draw) begin
                     xpos_q  <= xpos;
                     pal_q   <= pal;
                     code_q  <= code;
                     flip_q  <= flip_in;
                     addr_q  <= {code, 1'b0};
                     cs_q    <= 1'b1;
                     busy_q  <= 1'b1;
                     state_q <= REQ0;
                  end
               end
               REQ0, REQ1: begin
                  if (rom_ok) begin
                     data_q  <= rom_data;
                     cs_q    <= 1'b0;
                     cnt_q   <= 3'd0;
                     state_q <= (state_q == REQ0) ? DRAW0 : DRAW1;
                  end
               end
               DRAW0: begin
                  cnt_q <= cnt_q + 3'd1;
                  if (cnt_q == 3'd7) begin
                     addr_q  <= {code_q, 1'b1};
                     cs_q    <= 1'b1;
                     state_q <= REQ1;
                  end
               end
               DRAW1: begin
                  cnt_q <= cnt_q + 3'd1;
                  if (cnt_q == 3'd7) begin
                     busy_q  <= 1'b0;
                     state_q <= IDLE;
                  end
               end
               default: begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  cs_q    <= 1'b0;
               end
            endcase
         end
      end
   end

   // Read-then-erase keeps each bank clean for its next draw turn.
   always_ff @(posedge clk) begin
      if (rst) begin
         pxl_q   <= 8'h00;
         erase_q <= 1'b0;
         ebank_q <= 1'b0;
         eaddr_q <= 9'd0;
      end else begin
         erase_q <= 1'b0;
         if (pxl_cen) begin
            if (LHBL) begin
               pxl_q   <= bank_q ? buf0[h] : buf1[h];
               erase_q <= 1'b1;
               eaddr_q <= h;
               ebank_q <= ~bank_q;
            end else begin
               pxl_q <= 8'h00;
            end
         end
      end
   end

   assign busy     = busy_q;
   assign rom_cs   = cs_q;
   assign rom_addr = addr_q;
   assign pxl      = pxl_q;

endmodule

// File: tb/tb_jtvigil_obj_draw.sv
// tb_jtvigil_obj_draw: randomized sprite draws checked against a line-level
// model of the draw/display buffers.
module tb_jtvigil_obj_draw;

   logic        clk = 1'b0;
   logic        rst;
   logic        pxl_cen;
   logic        LHBL;
   logic [8:0]  h;
   logic        draw;
   logic        busy;
   logic [8:0]  xpos;
   logic [3:0]  pal;
   logic [16:0] code;
   logic        hflip;
   logic [17:0] rom_addr;
   logic        rom_cs;
   logic [31:0] rom_data;
   logic        rom_ok;
   logic [7:0]  pxl;

   int total = 0;
   int bad   = 0;
   int stall_cfg = 0;
   int wleft = 0;

   logic [31:0] rom_mem [0:255];
   logic [7:0]  mdraw [0:511];
   logic [7:0]  mdisp [0:511];

   always #5 clk = ~clk;

   jtvigil_obj_draw dut (
      .clk      (clk),
      .rst      (rst),
      .pxl_cen  (pxl_cen),
      .LHBL     (LHBL),
      .h        (h),
      .draw     (draw),
      .busy     (busy),
      .xpos     (xpos),
      .pal      (pal),
      .code     (code),
      .hflip    (hflip),
      .rom_addr (rom_addr),
      .rom_cs   (rom_cs),
      .rom_data (rom_data),
      .rom_ok   (rom_ok),
      .pxl      (pxl)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // ROM: answers after stall_cfg clocks, garbage on data while not ok
   initial begin
      rom_ok = 1'b0;
      rom_data = 32'd0;
      forever begin
         @(negedge clk);
         if (rom_cs) begin
            if (wleft > 0) begin
               wleft--;
               rom_ok = 1'b0;
               rom_data = $urandom;
            end else begin
               rom_ok = 1'b1;
               rom_data = rom_mem[rom_addr[7:0]];
            end
         end else begin
            rom_ok = 1'b0;
            wleft = stall_cfg;
            rom_data = $urandom;
         end
      end
   end

   task automatic model_draw(input int x, input int p, input int c,
                             input bit f, input int npix);
      bit ef;
`ifdef JTVIGIL_OBJ_HFLIP_EN
      ef = f;
`else
      ef = 1'b0;
`endif
      for (int k = 0; k < npix; k++) begin
         int n = k / 8;
         int i = k % 8;
         logic [31:0] w = rom_mem[(c * 2 + n) % 256];
         logic [3:0] nb = w[4 * i +: 4];
         int cc = ef ? (x + 15 - 8 * n - i) % 512 : (x + 8 * n + i) % 512;
         if (nb != 4'd0) mdraw[cc] = {p[3:0], nb};
      end
   endtask

   task automatic model_swap();
      for (int i = 0; i < 512; i++) begin
         logic [7:0] t = mdisp[i];
         mdisp[i] = mdraw[i];
         mdraw[i] = t;
      end
   endtask

   task automatic do_draw(input int x, input int p, input int c, input bit f,
                          input int stall, input bit spam);
      int n;
      int lim;
      stall_cfg = stall;
      lim = 20 + 2 * stall;
      @(negedge clk);
      xpos = x[8:0];
      pal = p[3:0];
      code = c[16:0];
      hflip = f;
      draw = 1'b1;
      @(posedge clk);
      #1;
      draw = 1'b0;
      check("busy_go", busy, 1);
      check("cs_go", rom_cs, 1);
      check("addr0", rom_addr, {c[16:0], 1'b0});
      n = 0;
      do begin
         if (spam && n == 2) begin
            @(negedge clk);
            xpos = 9'h1AA;
            code = 17'h3;
            draw = 1'b1;
         end
         @(posedge clk);
         #1;
         draw = 1'b0;
         n++;
         if (n <= stall) begin
            check("stall_cs", rom_cs, 1);
            check("stall_addr", rom_addr, {c[16:0], 1'b0});
            check("stall_busy", busy, 1);
         end
      end while (busy && n <= lim);
      check("done_lat", n <= lim, 1);
      check("busy_end", busy, 0);
      model_draw(x, p, c, f, 16);
   endtask

   task automatic scan_line(input bit chk);
      @(negedge clk);
      LHBL = 1'b1;
      for (int x = 0; x < 512; x++) begin
         @(negedge clk);
         h = x[8:0];
         pxl_cen = 1'b1;
         @(posedge clk);
         #1;
         pxl_cen = 1'b0;
         if (chk) check($sformatf("pxl h=%0d", x), pxl, mdisp[x]);
         mdisp[x] = 8'h00;
      end
   endtask

   task automatic end_line(input bit drop_draw);
      @(negedge clk);
      LHBL = 1'b0;
      if (drop_draw) begin
         xpos = 9'd10;
         pal = 4'd4;
         code = 17'd0;
         draw = 1'b1;
      end
      @(posedge clk);
      #1;
      draw = 1'b0;
      model_swap();
      check("busy_swap", busy, 0);
      check("cs_swap", rom_cs, 0);
      @(negedge clk);
      pxl_cen = 1'b1;
      @(posedge clk);
      #1;
      pxl_cen = 1'b0;
      check("pxl_blank", pxl, 0);
   endtask

   initial begin
      rst = 1'b1;
      pxl_cen = 1'b0;
      LHBL = 1'b0;
      h = 9'd0;
      draw = 1'b0;
      xpos = 9'd0;
      pal = 4'd0;
      code = 17'd0;
      hflip = 1'b0;
      for (int i = 0; i < 256; i++) begin
         logic [31:0] w;
         for (int k = 0; k < 8; k++)
            w[4 * k +: 4] = ($urandom_range(0, 3) == 0) ? 4'd0
                            : 4'($urandom_range(1, 15));
         rom_mem[i] = w;
      end
      rom_mem[0] = 32'h87654321;
      rom_mem[1] = 32'h87654321;
      for (int i = 0; i < 512; i++) begin
         mdraw[i] = 8'h00;
         mdisp[i] = 8'h00;
      end
      repeat (4) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_cs", rom_cs, 0);
      check("rst_addr", rom_addr, 0);
      check("rst_pxl", pxl, 0);
      @(negedge clk);
      rst = 1'b0;

      // flush power-up residue from both banks
      scan_line(1'b0);
      end_line(1'b0);
      scan_line(1'b0);
      end_line(1'b0);

      do_draw(100, 5, 0, 1'b0, 0, 1'b0);
      do_draw(508, 3, 0, 1'b0, 0, 1'b0);
      scan_line(1'b1);
      end_line(1'b0);

      do_draw(200, 6, 0, 1'b1, 0, 1'b0);
      do_draw(300, 7, 5, 1'b0, 20, 1'b1);
      scan_line(1'b1);
      end_line(1'b0);

      // abort: LHBL falls after three DRAW0 pixels
      scan_line(1'b1);
      stall_cfg = 0;
      @(negedge clk);
      xpos = 9'd50;
      pal = 4'd9;
      code = 17'd0;
      hflip = 1'b0;
      draw = 1'b1;
      @(posedge clk);
      #1;
      draw = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      LHBL = 1'b0;
      @(posedge clk);
      #1;
      check("abort_busy", busy, 0);
      check("abort_cs", rom_cs, 0);
      model_draw(50, 9, 0, 1'b0, 3);
      model_swap();
      repeat (25) @(posedge clk);
      #1;
      check("abort_idle", busy, 0);
      do_draw(400, 2, 0, 1'b0, 0, 1'b0);

      scan_line(1'b1);
      end_line(1'b1);
      scan_line(1'b1);
      end_line(1'b0);

      for (int ln = 0; ln < 8; ln++) begin
         int ns = $urandom_range(1, 4);
         for (int s = 0; s < ns; s++)
            do_draw($urandom_range(0, 511), $urandom_range(0, 15),
                    $urandom_range(0, 127), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)));
         scan_line(1'b1);
         end_line(1'b0);
      end

      // reset in the middle of a stalled ROM request
      stall_cfg = 10;
      @(negedge clk);
      code = 17'd9;
      draw = 1'b1;
      @(posedge clk);
      #1;
      draw = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("rrst_cs", rom_cs, 0);
      check("rrst_busy", busy, 0);
      check("rrst_addr", rom_addr, 0);
      check("rrst_pxl", pxl, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
